// File: rtl/io_arbiter_control_pkg.sv
// Shared constants for the IO arbiter: bus-side FSM encodings and width helpers.
package io_arbiter_control_pkg;

   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StReadBegin  = 3'd1,
      StReadWait   = 3'd2,
      StWriteBegin = 3'd3,
      StWriteWait  = 3'd4
   } io_state_e;

   // Width needed to index n items, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io_arbiter_control_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or after ptr, one-hot.
module io_arbiter_control_rr_arbiter
   import io_arbiter_control_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   localparam int unsigned PTR_W = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_CH-1:0] winner
);

   localparam logic [PTR_W:0] NumChL = (PTR_W + 1)'(NUM_CH);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum = {1'b0, ptr} + (PTR_W + 1)'(k);
         if (sum >= NumChL) begin
            sum = sum - NumChL;
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_arbiter_control.sv
// Multi-channel IO arbiter: grants one channel round-robin and runs a single
// read or write on the external bus with ready handshake and wait timeout.
module io_arbiter_control
   import io_arbiter_control_pkg::*;
#(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   input  logic                     ready,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic [NUM_CH-1:0]        gnt,
   output logic [NUM_CH-1:0]        done,
   output logic                     err,
   output logic [DATA_W-1:0]        rdata,
   output logic [2:0]               io_state
);

   localparam int unsigned PTR_W = clog2_min1(NUM_CH);
   localparam int unsigned CNT_W = clog2_min1(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   io_state_e        state_q;
   logic [PTR_W-1:0] rr_ptr_q;
   logic [CNT_W-1:0] wait_cnt_q;

   logic [NUM_CH-1:0] pick;
   logic [PTR_W-1:0]  pick_idx;
   logic [PTR_W-1:0]  next_ptr;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;
   logic              pick_we;

   io_arbiter_control_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .req    (req),
      .ptr    (rr_ptr_q),
      .winner (pick)
   );

   // Unpack the winner's request fields; pick is one-hot or zero.
   always_comb begin
      pick_idx   = '0;
      pick_addr  = '0;
      pick_wdata = '0;
      pick_we    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick[i]) begin
            pick_idx   = PTR_W'(i);
            pick_addr  = addr[i*ADDR_W +: ADDR_W];
            pick_wdata = wdata[i*DATA_W +: DATA_W];
            pick_we    = we[i];
         end
      end
      next_ptr = (pick_idx == PTR_W'(NUM_CH - 1)) ? '0 : pick_idx + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         wait_cnt_q <= '0;
         gnt        <= '0;
         done       <= '0;
         err        <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata      <= '0;
      end else begin
         done   <= '0;
         err    <= 1'b0;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         case (state_q)
            StIdle: begin
               if (|pick) begin
                  gnt       <= pick;
                  mem_addr  <= pick_addr;
                  mem_wdata <= pick_wdata;
                  rr_ptr_q  <= next_ptr;
                  if (pick_we) begin
                     mem_wr  <= 1'b1;
                     state_q <= StWriteBegin;
                  end else begin
                     mem_rd  <= 1'b1;
                     state_q <= StReadBegin;
                  end
               end
            end
            StReadBegin: begin
               wait_cnt_q <= '0;
               state_q    <= StReadWait;
            end
            StWriteBegin: begin
               wait_cnt_q <= '0;
               state_q    <= StWriteWait;
            end
            StReadWait, StWriteWait: begin
               // ready wins over a timeout landing in the same cycle
               if (ready) begin
                  state_q <= StIdle;
                  gnt     <= '0;
                  done    <= gnt;
                  if (state_q == StReadWait) begin
                     rdata <= mem_rdata;
                  end
               end else if ((TIMEOUT != 0) && (wait_cnt_q == CntLast)) begin
                  state_q <= StIdle;
                  gnt     <= '0;
                  done    <= gnt;
                  err     <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= StIdle;
               gnt     <= '0;
            end
         endcase
      end
   end

   assign io_state = state_q;

endmodule

// File: tb/tb_io_arbiter_control.sv
// Directed bench for io_arbiter_control: two channels, TIMEOUT=4.
module tb_io_arbiter_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [15:0] mem_rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic        err;
   logic [15:0] rdata;
   logic [2:0]  io_state;

   int errors = 0;
   int checks = 0;

   io_arbiter_control #(
      .NUM_CH  (2),
      .ADDR_W  (16),
      .DATA_W  (16),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ready     (ready),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .io_state  (io_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({io_state, gnt, done, err, mem_rd, mem_wr} !== 10'd0) begin
         $display("FAIL reset_ctrl: state=%0d gnt=%b done=%b err=%b rd=%b wr=%b, want all 0",
                  io_state, gnt, done, err, mem_rd, mem_wr);
         errors++;
      end
      checks++;
      if ({mem_addr, mem_wdata, rdata} !== 48'd0) begin
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want 0", mem_addr, mem_wdata, rdata);
         errors++;
      end
      reset = 1'b0;
   endtask

   task automatic test_read();
      req = 2'b01; we = 2'b00; addr = 32'h0000_0010; ready = 1'b0; mem_rdata = 16'hBEEF;
      tick();
      checks++;
      if ({io_state, gnt, mem_rd, mem_wr, mem_addr} !== {3'd1, 2'b01, 1'b1, 1'b0, 16'h0010}) begin
         $display("FAIL read_begin: state=%0d gnt=%b rd=%b wr=%b addr=%h, want 1 01 1 0 0010",
                  io_state, gnt, mem_rd, mem_wr, mem_addr);
         errors++;
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({io_state, gnt, mem_rd, done} !== {3'd2, 2'b01, 1'b0, 2'b00}) begin
            $display("FAIL read_wait%0d: state=%0d gnt=%b rd=%b done=%b, want 2 01 0 00",
                     c, io_state, gnt, mem_rd, done);
            errors++;
         end
      end
      tick();
      ready = 1'b1;
      tick();
      checks++;
      if ({io_state, gnt, done, err, rdata} !== {3'd0, 2'b00, 2'b01, 1'b0, 16'hBEEF}) begin
         $display("FAIL read_done: state=%0d gnt=%b done=%b err=%b rdata=%h, want 0 00 01 0 beef",
                  io_state, gnt, done, err, rdata);
         errors++;
      end
      req = 2'b00; ready = 1'b0;
      tick();
      checks++;
      if ({io_state, done, rdata} !== {3'd0, 2'b00, 16'hBEEF}) begin
         $display("FAIL read_after: state=%0d done=%b rdata=%h, want 0 00 beef",
                  io_state, done, rdata);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req = 2'b11; we = 2'b00; addr = 32'h0101_0100; ready = 1'b1; mem_rdata = 16'h1111;
      for (int t = 0; t < 4; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         checks++;
         if ({io_state, gnt, mem_rd, mem_addr} !==
             {3'd1, exp_g, 1'b1, (t % 2 == 0) ? 16'h0100 : 16'h0101}) begin
            $display("FAIL b2b_grant%0d: state=%0d gnt=%b rd=%b addr=%h, want 1 %b 1",
                     t, io_state, gnt, mem_rd, mem_addr, exp_g);
            errors++;
         end
         tick();
         checks++;
         if ({io_state, gnt, done} !== {3'd2, exp_g, 2'b00}) begin
            $display("FAIL b2b_wait%0d: state=%0d gnt=%b done=%b, want 2 %b 00",
                     t, io_state, gnt, done, exp_g);
            errors++;
         end
         tick();
         checks++;
         if ({io_state, gnt, done, err, rdata} !== {3'd0, 2'b00, exp_g, 1'b0, 16'h1111}) begin
            $display("FAIL b2b_done%0d: state=%0d gnt=%b done=%b err=%b rdata=%h, want 0 00 %b 0 1111",
                     t, io_state, gnt, done, err, rdata, exp_g);
            errors++;
         end
      end
      req = 2'b00; ready = 1'b0;
      tick();
   endtask

   task automatic test_write();
      req = 2'b10; we = 2'b10; addr = 32'h0200_AAAA; wdata = 32'h1234_5555; ready = 1'b0;
      mem_rdata = 16'h7777;
      tick();
      checks++;
      if ({io_state, gnt, mem_wr, mem_rd, mem_addr, mem_wdata} !==
          {3'd3, 2'b10, 1'b1, 1'b0, 16'h0200, 16'h1234}) begin
         $display("FAIL write_begin: state=%0d gnt=%b wr=%b rd=%b addr=%h wdata=%h, want 3 10 1 0 0200 1234",
                  io_state, gnt, mem_wr, mem_rd, mem_addr, mem_wdata);
         errors++;
      end
      tick();
      checks++;
      if ({io_state, mem_wr, mem_addr, mem_wdata} !== {3'd4, 1'b0, 16'h0200, 16'h1234}) begin
         $display("FAIL write_wait: state=%0d wr=%b addr=%h wdata=%h, want 4 0 0200 1234",
                  io_state, mem_wr, mem_addr, mem_wdata);
         errors++;
      end
      ready = 1'b1;
      tick();
      checks++;
      if ({io_state, done, err, rdata} !== {3'd0, 2'b10, 1'b0, 16'h1111}) begin
         $display("FAIL write_done: state=%0d done=%b err=%b rdata=%h, want 0 10 0 1111",
                  io_state, done, err, rdata);
         errors++;
      end
      req = 2'b00; we = 2'b00; ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      req = 2'b01; we = 2'b00; addr = 32'h0000_0040; ready = 1'b0; mem_rdata = 16'hDEAD;
      tick();
      checks++;
      if (io_state !== 3'd1) begin
         $display("FAIL to_begin: state=%0d, want 1", io_state);
         errors++;
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if ({io_state, err, done} !== {3'd2, 1'b0, 2'b00}) begin
            $display("FAIL to_wait%0d: state=%0d err=%b done=%b, want 2 0 00", c, io_state, err, done);
            errors++;
         end
      end
      tick();
      checks++;
      if ({io_state, gnt, done, err, rdata} !== {3'd0, 2'b00, 2'b01, 1'b1, 16'h1111}) begin
         $display("FAIL to_abort: state=%0d gnt=%b done=%b err=%b rdata=%h, want 0 00 01 1 1111",
                  io_state, gnt, done, err, rdata);
         errors++;
      end
      req = 2'b00;
      tick();
      checks++;
      if ({done, err} !== 3'b000) begin
         $display("FAIL to_clear: done=%b err=%b, want 00 0", done, err);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      req = 2'b01; we = 2'b00; ready = 1'b0;
      tick();
      tick();
      checks++;
      if (io_state !== 3'd2) begin
         $display("FAIL rst_mid_pre: state=%0d, want 2", io_state);
         errors++;
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({io_state, gnt, done, err, mem_rd, mem_wr, mem_addr, mem_wdata, rdata} !== 58'd0) begin
         $display("FAIL rst_mid: state=%0d gnt=%b done=%b err=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, want 0",
                  io_state, gnt, done, err, mem_rd, mem_wr, mem_addr, mem_wdata, rdata);
         errors++;
      end
      reset = 1'b0; req = 2'b11;
      tick();
      checks++;
      if (gnt !== 2'b01) begin
         $display("FAIL rst_ptr_both: gnt=%b, want 01", gnt);
         errors++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; req = 2'b10;
      tick();
      checks++;
      if ({io_state, gnt} !== {3'd1, 2'b10}) begin
         $display("FAIL rst_ptr_ch1: state=%0d gnt=%b, want 1 10", io_state, gnt);
         errors++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; req = 2'b00;
   endtask

   task automatic test_ready_corner();
      ready = 1'b1; req = 2'b00;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({io_state, done, err} !== {3'd0, 2'b00, 1'b0}) begin
            $display("FAIL idle_ready%0d: state=%0d done=%b err=%b, want 0 00 0", c, io_state, done, err);
            errors++;
         end
      end
      req = 2'b01; we = 2'b00; addr = 32'h0000_0080;
      tick();
      tick();
      checks++;
      if ({io_state, done} !== {3'd2, 2'b00}) begin
         $display("FAIL begin_ready: state=%0d done=%b, want 2 00", io_state, done);
         errors++;
      end
      ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
      end
      ready = 1'b1; mem_rdata = 16'hC0DE;
      tick();
      checks++;
      if ({io_state, done, err, rdata} !== {3'd0, 2'b01, 1'b0, 16'hC0DE}) begin
         $display("FAIL ready_at_timeout: state=%0d done=%b err=%b rdata=%h, want 0 01 0 c0de",
                  io_state, done, err, rdata);
         errors++;
      end
      req = 2'b00; ready = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; ready = 1'b0; mem_rdata = '0;
      test_reset();
      test_read();
      test_back_to_back();
      test_write();
      test_timeout();
      test_reset_mid();
      test_ready_corner();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_arbiter_control.md
IO_ARBITER_CONTROL -- requirements
Module: io_arbiter_control

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of requesting channels (1..8).
REQ-002 The block SHALL have parameter ADDR_W, default 16, address width.
REQ-003 The block SHALL have parameter DATA_W, default 16, data width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, maximum wait cycles before abort; 0 disables timeout.
REQ-005 The block SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-006 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port req  input  NUM_CH  per-channel transaction request, held until that channel's done.
REQ-008 The block SHALL have port we  input  NUM_CH  per-channel direction: 1 write, 0 read.
REQ-009 The block SHALL have port addr  input  NUM_CH*ADDR_W  packed per-channel address; channel i at [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port wdata  input  NUM_CH*DATA_W  packed per-channel write data.
REQ-011 The block SHALL have port ready  input  1  memory/IO completion strobe.
REQ-012 The block SHALL have port mem_rdata  input  DATA_W  read data, valid when ready=1.
REQ-013 The block SHALL have ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_rd (1), mem_wr (1), all outputs, driving the external bus.
REQ-014 The block SHALL have ports gnt (NUM_CH, one-hot or zero), done (NUM_CH), err (1), rdata (DATA_W), io_state (3), all outputs.

Function
REQ-015 The FSM SHALL have states IDLE=0, READ_BEGIN=1, READ_WAIT=2, WRITE_BEGIN=3, WRITE_WAIT=4; io_state SHALL present the current state.
REQ-016 In IDLE with any req bit set, the block SHALL pick one channel round-robin, starting from the channel after the last granted (channel 0 after reset), and enter WRITE_BEGIN if its we=1, else READ_BEGIN.
REQ-017 On that transition the block SHALL register the winner's addr, wdata, we into mem_addr, mem_wdata and set gnt to the winner one-hot; these SHALL remain stable until return to IDLE.
REQ-018 In READ_BEGIN/WRITE_BEGIN, mem_rd/mem_wr SHALL be 1 for exactly that one cycle; next state is READ_WAIT/WRITE_WAIT.
REQ-019 In a WAIT state with ready=1 the block SHALL go to IDLE, pulse done[winner] for one cycle coinciding with IDLE entry, and on reads capture mem_rdata into rdata (held until next read completes).
REQ-020 ready in IDLE or BEGIN states SHALL be ignored.
REQ-021 A wait counter SHALL clear on BEGIN and increment each WAIT cycle with ready=0; when it reaches TIMEOUT (TIMEOUT>0), the block SHALL go to IDLE, pulse done[winner] and err together, and leave rdata unchanged.
REQ-022 ready=1 in the same cycle the counter reaches TIMEOUT SHALL count as success (no err).
REQ-023 gnt SHALL be zero in IDLE; done and err SHALL be zero except as pulsed above.
REQ-024 Minimum transaction cost SHALL be 3 cycles (IDLE decision, BEGIN, WAIT with ready); a new grant MAY occur in the cycle after done.
REQ-025 A request deasserted before grant SHALL be dropped silently; deassertion after grant SHALL NOT abort the transaction.
REQ-026 Any undefined io_state SHALL return to IDLE next cycle.

Reset
REQ-027 On reset=1 at a clock edge: io_state=IDLE, gnt=0, done=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, wait counter=0, round-robin pointer=channel 0.
REQ-028 Reset mid-transaction SHALL abort it with no done/err pulse.

Structure
REQ-029 io state encodings SHALL live in the shared constants file type.v alongside the existing cpu/io state definitions.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last-grant pointer; output one-hot winner), purely combinational.

Verification
REQ-031 NUM_CH=2, ch0 read addr 0x0010, ready after 2 WAIT cycles with mem_rdata 0xBEEF -> mem_rd one cycle, done[0] pulse, rdata=0xBEEF, err=0.
REQ-032 Both channels request continuously, ready immediate -> grants alternate 0,1,0,1; each transaction 3 cycles.
REQ-033 ch1 write addr 0x0200 data 0x1234 -> mem_wr one cycle with mem_addr=0x0200, mem_wdata=0x1234; done[1] on ready.
REQ-034 TIMEOUT=4, ready never asserted -> after 4 WAIT cycles err and done pulse together, io_state=IDLE, rdata unchanged.
REQ-035 Reset asserted during READ_WAIT -> next cycle all outputs at reset values, no done/err; subsequent request by ch1 granted first only if ch0 idle (pointer back at 0).
REQ-036 ready pulsed while IDLE, and ready coinciding with timeout cycle -> first ignored, second completes with err=0.
